// File: rtl/autoencoder_defs.sv
// Shared definitions for the autoencoder instruction path: opcode constants,
// instruction field slices and the fetch sequencer state encoding.
package autoencoder_defs;

  localparam logic [3:0] HALT_OP = 4'hF;
  localparam logic [3:0] LOOP_OP = 4'hE;

  typedef enum logic [2:0] {
    FS_IDLE  = 3'd0,
    FS_FETCH = 3'd1,
    FS_LATCH = 3'd2,
    FS_ISSUE = 3'd3,
    FS_DONE  = 3'd4
  } fetch_state_t;

  // Instruction layout: opcode[15:12] field1[11:8] field2[7:4] field3[3:0]
  function automatic logic [3:0] opcode_of(input logic [15:0] w);
    return w[15:12];
  endfunction

  function automatic logic [3:0] field1_of(input logic [15:0] w);
    return w[11:8];
  endfunction

  function automatic logic [3:0] field2_of(input logic [15:0] w);
    return w[7:4];
  endfunction

  function automatic logic [3:0] field3_of(input logic [15:0] w);
    return w[3:0];
  endfunction

endpackage

// File: rtl/instr_mem.sv
// Program RAM: DEPTH x INSTR_W, synchronous write, synchronous read with
// one cycle of read latency. Contents are not reset.
module instr_mem #(
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 2**ADDR_W,
  parameter int INSTR_W = 16
) (
  input  logic               clock,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction memory plus fetch sequencer issuing one instruction at a time
// over a valid/ready handshake. Optional hardware loop: define INSTR_LOOP_EN.
module instr_fetch_unit
  import autoencoder_defs::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 2**ADDR_W,
  parameter int INSTR_W = 16
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               busy,
  output logic               done,
  output logic               err_wrap,
  output fetch_state_t       fsm_state
);

  // Handshake: instr_out/instr_valid are held unchanged while instr_valid=1
  // and instr_ready=0; a transfer happens on a rising edge where both are 1.
  // Only abort or reset may drop instr_valid without a transfer.

  logic [INSTR_W-1:0] rdata;
  logic               mem_we;
  logic [ADDR_W-1:0]  pc_inc;
  logic               pc_at_end;
  logic [3:0]         opcode;

  assign mem_we    = prog_we && (fsm_state == FS_IDLE || fsm_state == FS_DONE);
  assign pc_inc    = pc_out + ADDR_W'(1);
  assign pc_at_end = (pc_out == {ADDR_W{1'b1}});
  assign opcode    = opcode_of(rdata);

  instr_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .INSTR_W(INSTR_W)
  ) u_mem (
    .clock(clock),
    .we   (mem_we),
    .waddr(prog_addr),
    .wdata(prog_data),
    .raddr(pc_out),
    .rdata(rdata)
  );

`ifdef INSTR_LOOP_EN
  logic [3:0]        loop_cnt;
  logic [ADDR_W-1:0] loop_target;
  logic [3:0]        loop_count;

  assign loop_target = rdata[ADDR_W+3:4];
  assign loop_count  = field3_of(rdata);
`endif

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      fsm_state   <= FS_IDLE;
      pc_out      <= '0;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_wrap    <= 1'b0;
`ifdef INSTR_LOOP_EN
      loop_cnt    <= '0;
`endif
    end else if (abort) begin
      fsm_state   <= FS_IDLE;
      pc_out      <= '0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef INSTR_LOOP_EN
      loop_cnt    <= '0;
`endif
    end else begin
      case (fsm_state)
        FS_IDLE, FS_DONE: begin
          if (start) begin
            fsm_state <= FS_FETCH;
            pc_out    <= '0;
            err_wrap  <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
`ifdef INSTR_LOOP_EN
            loop_cnt  <= '0;
`endif
          end
        end
        FS_FETCH: begin
          fsm_state <= FS_LATCH;
        end
        FS_LATCH: begin
          if (opcode == HALT_OP) begin
            fsm_state <= FS_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
`ifdef INSTR_LOOP_EN
          end else if (opcode == LOOP_OP) begin
            // LOOP is consumed here and never reaches the datapath
            fsm_state <= FS_FETCH;
            if (loop_cnt == 4'd0 && loop_count != 4'd0) begin
              loop_cnt <= loop_count;
              pc_out   <= loop_target;
            end else if (loop_cnt > 4'd1) begin
              loop_cnt <= loop_cnt - 4'd1;
              pc_out   <= loop_target;
            end else begin
              loop_cnt <= '0;
              pc_out   <= pc_inc;
              if (pc_at_end) err_wrap <= 1'b1;
            end
`endif
          end else begin
            fsm_state   <= FS_ISSUE;
            instr_out   <= rdata;
            instr_valid <= 1'b1;
            pc_out      <= pc_inc;
            if (pc_at_end) err_wrap <= 1'b1;
          end
        end
        FS_ISSUE: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            fsm_state   <= FS_FETCH;
          end
        end
        default: begin
          fsm_state <= FS_IDLE;
        end
      endcase
    end
  end

endmodule
